uart_xfer_ctrl: RTL and testbench

- Sequencer between the bus-side UART peripheral registers and the uart core.
- TX: queues CPU-written bytes in a small FIFO and issues core write strobes only when the core is idle. Software no longer has to poll tx_busy per byte.
- RX: runs a 4-phase ack handshake with the core and holds received bytes in a holding register, with sticky overrun, error and drop flags for the status register.

---
 rtl/uart_xfer_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_xfer_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xfer_ctrl.sv
// Sequencer between the bus-side UART registers and the uart core: TX byte queue with
// idle-gated write strobes, RX 4-phase ack handshake with a holding register and sticky flags.
module uart_xfer_ctrl #(
    parameter int TXQ_AW  = 3,
    parameter int BUSY_TO = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              txq_full,
    output logic              txq_empty,
    output logic [TXQ_AW:0]   txq_level,
    output logic              tx_drop,
    output logic [7:0]        core_tx_data,
    output logic              core_tx_wr,
    input  logic              core_tx_busy,
    input  logic [7:0]        core_rx_data,
    input  logic              core_rx_avail,
    input  logic              core_rx_error,
    output logic              core_rx_ack,
    input  logic              rd_en,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              rx_overrun,
    output logic              rx_err,
    input  logic              clr_flags
);
    localparam int DEPTH = 1 << TXQ_AW;
    localparam int TOW   = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {T_IDLE, T_STROBE, T_WAIT_BUSY, T_WAIT_DONE} tx_state_e;
    typedef enum logic {R_IDLE, R_ACK} rx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    rx_state_e         rx_state_q, rx_state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [TXQ_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TXQ_AW:0]   level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d, drop_q, drop_d;
    logic [7:0]        txd_q, txd_d;
    logic              txwr_q, txwr_d;
    logic [TOW-1:0]    to_q, to_d;
    logic              ack_q, ack_d;
    logic [7:0]        rxd_q, rxd_d;
    logic              valid_q, valid_d, ovr_q, ovr_d, err_q, err_d;
    logic              pop, push, ovr_set, err_set;

    always_comb begin
        tx_state_d = tx_state_q;
        txwr_d     = 1'b0;
        txd_d      = txd_q;
        to_d       = to_q;
        pop        = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!empty_q && !core_tx_busy) begin
                    pop        = 1'b1;
                    txd_d      = mem_q[rptr_q];
                    txwr_d     = 1'b1;
                    tx_state_d = T_STROBE;
                end
            end
            T_STROBE: begin
                to_d       = '0;
                tx_state_d = T_WAIT_BUSY;
            end
            T_WAIT_BUSY: begin
                // A core that never reports busy must not stall the queue forever
                if (core_tx_busy)
                    tx_state_d = T_WAIT_DONE;
                else if (to_q == TOW'(BUSY_TO - 1))
                    tx_state_d = T_IDLE;
                else
                    to_d = to_q + 1'b1;
            end
            T_WAIT_DONE: begin
                if (!core_tx_busy)
                    tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        push    = wr_en && (!full_q || pop);
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == (TXQ_AW+1)'(DEPTH));
        empty_d = (level_d == '0);
        drop_d  = (wr_en && !push) ? 1'b1 : (clr_flags ? 1'b0 : drop_q);
    end

    always_comb begin
        rx_state_d = rx_state_q;
        ack_d      = ack_q;
        rxd_d      = rxd_q;
        valid_d    = valid_q && !rd_en;
        ovr_set    = 1'b0;
        err_set    = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (core_rx_avail) begin
                    if (!core_rx_error) begin
                        rxd_d   = core_rx_data;
                        valid_d = 1'b1;
                        ovr_set = valid_q && !rd_en;
                    end else begin
                        err_set = 1'b1;
                    end
                    ack_d      = 1'b1;
                    rx_state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (!core_rx_avail) begin
                    ack_d      = 1'b0;
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
        ovr_d = ovr_set || (ovr_q && !clr_flags);
        err_d = err_set || (err_q && !clr_flags);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= T_IDLE;
            rx_state_q <= R_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            drop_q     <= 1'b0;
            txd_q      <= '0;
            txwr_q     <= 1'b0;
            to_q       <= '0;
            ack_q      <= 1'b0;
            rxd_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            drop_q     <= drop_d;
            txd_q      <= txd_d;
            txwr_q     <= txwr_d;
            to_q       <= to_d;
            ack_q      <= ack_d;
            rxd_q      <= rxd_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            err_q      <= err_d;
        end
    end

    assign txq_full     = full_q;
    assign txq_empty    = empty_q;
    assign txq_level    = level_q;
    assign tx_drop      = drop_q;
    assign core_tx_data = txd_q;
    assign core_tx_wr   = txwr_q;
    assign core_rx_ack  = ack_q;
    assign rx_data      = rxd_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_err       = err_q;
endmodule

// File: tb/tb_uart_xfer_ctrl.sv
// Bench for uart_xfer_ctrl: directed steps plus a random phase, checked every cycle
// against a queue-based model of the TX byte stream and the RX holding register.
module tb_uart_xfer_ctrl;
    localparam int TXQ_AW  = 3;
    localparam int BUSY_TO = 16;
    localparam int DEPTH   = 1 << TXQ_AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en, rd_en, clr_flags;
    logic [7:0]      wr_data, core_rx_data;
    logic            core_tx_busy, core_rx_avail, core_rx_error;
    logic            txq_full, txq_empty, tx_drop, core_tx_wr, core_rx_ack;
    logic [TXQ_AW:0] txq_level;
    logic [7:0]      core_tx_data, rx_data;
    logic            rx_valid, rx_overrun, rx_err;

    always #5 clk = ~clk;

    uart_xfer_ctrl #(.TXQ_AW(TXQ_AW), .BUSY_TO(BUSY_TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .txq_full(txq_full), .txq_empty(txq_empty), .txq_level(txq_level), .tx_drop(tx_drop),
        .core_tx_data(core_tx_data), .core_tx_wr(core_tx_wr), .core_tx_busy(core_tx_busy),
        .core_rx_data(core_rx_data), .core_rx_avail(core_rx_avail), .core_rx_error(core_rx_error),
        .core_rx_ack(core_rx_ack), .rd_en(rd_en), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_overrun(rx_overrun), .rx_err(rx_err), .clr_flags(clr_flags)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // model state
    logic [7:0] expq[$];
    logic [7:0] rcv[$];
    logic [7:0] m_txdata, m_rxdata;
    bit         m_drop, m_ack, m_valid, m_ovr, m_err;
    int         cyc_no, last_strobe, prev_strobe;
    bit         wr_prev;
    int         busy_cnt, busy_len;
    bit         force_busy, never_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_busy();
        core_tx_busy = force_busy || (busy_cnt > 0);
    endtask

    task automatic reset_model();
        expq.delete();
        m_txdata = '0; m_rxdata = '0;
        m_drop = 0; m_ack = 0; m_valid = 0; m_ovr = 0; m_err = 0;
        wr_prev = 0; busy_cnt = 0; force_busy = 0;
        upd_busy();
    endtask

    // One clock: apply the behavioural rules to the inputs seen at the edge, then compare.
    task automatic cyc();
        bit p_wr, p_busy, p_av, p_er, p_rd, p_clr, strobe, tx_set, ovr_set, err_set;
        logic [7:0] p_wd, p_rxd;
        int pre;
        p_wr = wr_en; p_wd = wr_data; p_busy = core_tx_busy;
        p_av = core_rx_avail; p_er = core_rx_error; p_rxd = core_rx_data;
        p_rd = rd_en; p_clr = clr_flags;
        pre = expq.size();
        tx_set = 0; ovr_set = 0; err_set = 0;
        @(posedge clk); #1;
        cyc_no++;
        strobe = (core_tx_wr === 1'b1);
        if (strobe) begin
            chk("tx_wr_one_cycle", 32'(wr_prev), 0);
            chk("tx_core_idle_at_pop", 32'(p_busy), 0);
            chk("tx_pop_nonempty", 32'(pre > 0), 1);
            if (pre > 0) m_txdata = expq.pop_front();
            rcv.push_back(core_tx_data);
            prev_strobe = last_strobe;
            last_strobe = cyc_no;
            if (!never_busy) busy_cnt = busy_len;
        end
        wr_prev = strobe;
        if (p_wr) begin
            if (pre < DEPTH || strobe) expq.push_back(p_wd);
            else tx_set = 1;
        end
        if (!m_ack && p_av) begin
            if (!p_er) begin
                ovr_set  = m_valid && !p_rd;
                m_rxdata = p_rxd;
                m_valid  = 1;
            end else begin
                err_set = 1;
                if (p_rd) m_valid = 0;
            end
            m_ack = 1;
        end else begin
            if (p_rd) m_valid = 0;
            if (m_ack && !p_av) m_ack = 0;
        end
        m_drop = tx_set  ? 1'b1 : (p_clr ? 1'b0 : m_drop);
        m_ovr  = ovr_set ? 1'b1 : (p_clr ? 1'b0 : m_ovr);
        m_err  = err_set ? 1'b1 : (p_clr ? 1'b0 : m_err);
        chk("txq_level", txq_level, expq.size());
        chk("txq_full", txq_full, 32'(expq.size() == DEPTH));
        chk("txq_empty", txq_empty, 32'(expq.size() == 0));
        chk("tx_drop", tx_drop, m_drop);
        chk("core_tx_data", core_tx_data, m_txdata);
        chk("core_rx_ack", core_rx_ack, m_ack);
        chk("rx_data", rx_data, m_rxdata);
        chk("rx_valid", rx_valid, m_valid);
        chk("rx_overrun", rx_overrun, m_ovr);
        chk("rx_err", rx_err, m_err);
        upd_busy();
        if (busy_cnt > 0) busy_cnt--;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1; wr_data = b;
        cyc();
        wr_en = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, gap, n0;
        logic [7:0] x;
        rst = 0; wr_en = 0; wr_data = 0; rd_en = 0; clr_flags = 0;
        core_rx_data = 0; core_rx_avail = 0; core_rx_error = 0;
        cyc_no = 0; last_strobe = 0; prev_strobe = 0;
        never_busy = 0; busy_len = 3;
        reset_model();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", txq_empty, 1);
        chk("rst_full", txq_full, 0);
        chk("rst_level", txq_level, 0);
        chk("rst_tx_wr", core_tx_wr, 0);
        chk("rst_tx_data", core_tx_data, 0);
        chk("rst_ack", core_rx_ack, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_flags", {tx_drop, rx_overrun, rx_err}, 0);
        rst = 1;
        repeat (2) cyc();

        // single byte latency and strobe width
        push_byte(8'h55);
        chk("t1_no_strobe_at_push", core_tx_wr, 0);
        cyc();
        chk("t1_strobe", core_tx_wr, 1);
        chk("t1_data", core_tx_data, 8'h55);
        chk("t1_level", txq_level, 0);
        cyc();
        chk("t1_strobe_low", core_tx_wr, 0);
        repeat (10) cyc();

        // fill while core busy, overflow drop, then ordered drain
        force_busy = 1; upd_busy();
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        chk("t2_level8", txq_level, 8);
        chk("t2_full", txq_full, 1);
        chk("t2_drop", tx_drop, 1);
        rcv.delete();
        force_busy = 0; upd_busy();
        k = 0;
        while (rcv.size() < 8 && k < 400) begin cyc(); k++; end
        chk("t2_drain_count", rcv.size(), 8);
        for (int i = 0; i < 8 && i < rcv.size(); i++) chk("t2_order", rcv[i], i + 1);
        repeat (10) cyc();
        chk("t2_sent_only_8", rcv.size(), 8);

        // simultaneous pop and push at full
        clr_flags = 1; cyc(); clr_flags = 0;
        chk("t3_drop_cleared", tx_drop, 0);
        force_busy = 1; upd_busy();
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        chk("t3_full", txq_full, 1);
        rcv.delete();
        x = 8'hC7;
        force_busy = 0; upd_busy();
        wr_en = 1; wr_data = x;
        cyc();
        wr_en = 0;
        chk("t3_pop", core_tx_wr, 1);
        chk("t3_level_kept", txq_level, 8);
        chk("t3_no_drop", tx_drop, 0);
        k = 0;
        while (rcv.size() < 9 && k < 400) begin cyc(); k++; end
        chk("t3_drain_count", rcv.size(), 9);
        if (rcv.size() == 9) chk("t3_new_last", rcv[8], x);
        repeat (10) cyc();

        // core never reports busy: timeout then next byte
        never_busy = 1;
        rcv.delete();
        push_byte(8'hA1);
        push_byte(8'hB2);
        k = 0;
        while (rcv.size() < 2 && k < 100) begin cyc(); k++; end
        chk("t4_two_strobes", rcv.size(), 2);
        gap = last_strobe - prev_strobe;
        chk("t4_timeout_gap", 32'(gap >= BUSY_TO + 1 && gap <= BUSY_TO + 3), 1);
        repeat (20) cyc();
        never_busy = 0;

        // RX capture, ack hold, overrun, clear
        core_rx_data = 8'hA3; core_rx_avail = 1;
        cyc();
        chk("t5_rx_data", rx_data, 8'hA3);
        chk("t5_rx_valid", rx_valid, 1);
        chk("t5_ack", core_rx_ack, 1);
        repeat (3) cyc();
        chk("t5_ack_held", core_rx_ack, 1);
        core_rx_avail = 0;
        cyc();
        chk("t5_ack_drop", core_rx_ack, 0);
        core_rx_data = 8'h3C; core_rx_avail = 1;
        cyc();
        chk("t5_rx_data2", rx_data, 8'h3C);
        chk("t5_overrun", rx_overrun, 1);
        core_rx_avail = 0;
        cyc();
        clr_flags = 1; cyc(); clr_flags = 0;
        chk("t5_ovr_cleared", rx_overrun, 0);
        rd_en = 1; cyc(); rd_en = 0;
        chk("t5_rd_clears", rx_valid, 0);
        core_rx_data = 8'h11; core_rx_avail = 1; cyc();
        core_rx_avail = 0; cyc();
        core_rx_data = 8'h5A; core_rx_avail = 1; rd_en = 1;
        cyc();
        rd_en = 0;
        chk("t5_capture_wins_valid", rx_valid, 1);
        chk("t5_capture_wins_ovr", rx_overrun, 0);
        core_rx_avail = 0; cyc();

        // errored frame
        core_rx_data = 8'hFF; core_rx_error = 1; core_rx_avail = 1;
        cyc();
        chk("t6_err", rx_err, 1);
        chk("t6_valid_kept", rx_valid, 1);
        chk("t6_data_kept", rx_data, 8'h5A);
        chk("t6_ack", core_rx_ack, 1);
        core_rx_avail = 0; core_rx_error = 0;
        cyc();
        chk("t6_ack_done", core_rx_ack, 0);

        // random traffic on both paths
        for (int i = 0; i < 600; i++) begin
            wr_en     = ($urandom % 4 == 0);
            wr_data   = 8'($urandom);
            rd_en     = ($urandom % 5 == 0);
            clr_flags = ($urandom % 23 == 0);
            busy_len  = $urandom_range(1, 6);
            if (!core_rx_avail && !core_rx_ack && ($urandom % 6 == 0)) begin
                core_rx_avail = 1; core_rx_data = 8'($urandom); core_rx_error = ($urandom % 5 == 0);
            end else if (core_rx_avail && core_rx_ack && ($urandom % 2 == 0)) begin
                core_rx_avail = 0; core_rx_error = 0;
            end
            cyc();
        end
        wr_en = 0; rd_en = 0; clr_flags = 0; core_rx_avail = 0; core_rx_error = 0;
        repeat (80) cyc();

        // asynchronous reset while waiting for the core to finish
        busy_len = 10;
        rcv.delete();
        push_byte(8'h9E);
        k = 0;
        while (rcv.size() < 1 && k < 20) begin cyc(); k++; end
        chk("t7_strobe_seen", rcv.size(), 1);
        push_byte(8'h4D);
        repeat (3) cyc();
        #2 rst = 0;
        #1;
        chk("t7_tx_wr", core_tx_wr, 0);
        chk("t7_tx_data", core_tx_data, 0);
        chk("t7_ack", core_rx_ack, 0);
        chk("t7_level", txq_level, 0);
        chk("t7_empty", txq_empty, 1);
        chk("t7_full", txq_full, 0);
        chk("t7_rx", {rx_data, rx_valid}, 0);
        chk("t7_flags", {tx_drop, rx_overrun, rx_err}, 0);
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        n0 = rcv.size();
        repeat (20) cyc();
        chk("t7_no_strobe_after", rcv.size(), n0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
